// File: rtl/upsert_engine.sv
// Single-request upsert sequencer: looks up a key, then writes to the hit entry,
// the first free entry, or a round-robin victim, and reports done/error.
module upsert_engine #(
    parameter int NUM_ENTRIES = 8,
    parameter bit EVICT_EN    = 1'b0,
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   lookup_req,
    input  logic                   lookup_valid,
    input  logic                   hit,
    input  logic [NUM_ENTRIES-1:0] idx_in,
    input  logic [NUM_ENTRIES-1:0] used,
    output logic                   select_out,
    output logic                   write_out,
    output logic [NUM_ENTRIES-1:0] idx_out,
    output logic                   evict_out,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, WRITE, RESP} state_t;

    state_t                 state;
    logic [7:0]             cnt;
    logic [NUM_ENTRIES-1:0] victim;
    logic [NUM_ENTRIES-1:0] free_idx;
    logic                   free_found;
    logic                   idx_onehot;
    logic                   all_used;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (!used[i] && !free_found) begin
                free_idx[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    always_comb begin
        idx_onehot = $onehot(idx_in);
        all_used   = &used;
    end

    // idx_out/select_out/evict_out double as the registered write target:
    // they are loaded on the WAIT->WRITE edge and cleared on every other edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            victim     <= NUM_ENTRIES'(1);
            busy       <= 1'b0;
            lookup_req <= 1'b0;
            write_out  <= 1'b0;
            select_out <= 1'b0;
            evict_out  <= 1'b0;
            idx_out    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            lookup_req <= 1'b0;
            write_out  <= 1'b0;
            select_out <= 1'b0;
            evict_out  <= 1'b0;
            idx_out    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOOKUP;
                        busy       <= 1'b1;
                        lookup_req <= 1'b1;
                        err_code   <= 2'b00;
                    end
                end
                LOOKUP: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (lookup_valid) begin
                        if (hit) begin
                            if (idx_onehot) begin
                                state      <= WRITE;
                                write_out  <= 1'b1;
                                select_out <= 1'b1;
                                idx_out    <= idx_in;
                            end else begin
                                state    <= RESP;
                                error    <= 1'b1;
                                err_code <= 2'b11;
                            end
                        end else if (!all_used) begin
                            state     <= WRITE;
                            write_out <= 1'b1;
                            idx_out   <= free_idx;
                        end else if (EVICT_EN) begin
                            state     <= WRITE;
                            write_out <= 1'b1;
                            evict_out <= 1'b1;
                            idx_out   <= victim;
                        end else begin
                            state    <= RESP;
                            error    <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state    <= RESP;
                        error    <= 1'b1;
                        err_code <= 2'b10;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WRITE: begin
                    state <= RESP;
                    done  <= 1'b1;
                    if (evict_out) begin
                        victim <= {victim[NUM_ENTRIES-2:0], victim[NUM_ENTRIES-1]};
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
